coin_input_conditioner: RTL and testbench

//   Front end of the vending machine, directly upstream of the vending FSM.

---
 rtl/coin_input_conditioner.sv | 203 ++++++++++++++++++++
 tb/tb_coin_input_conditioner.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/coin_input_conditioner.sv
// Coin input conditioner: synchronizes and debounces three coin sensors, arbitrates
// qualified coins into exclusive one-cycle pulses, and detects a jammed coin path.
module coin_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int JAM_CYCLES      = 1000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_enable,
  input  logic i_nickle_raw,
  input  logic i_dime_raw,
  input  logic i_quarter_raw,
  output logic o_nickle,
  output logic o_dime,
  output logic o_quarter,
  output logic o_reject,
  output logic o_jam
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int JW = $clog2(JAM_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [JW-1:0] JAM_ONE  = JW'(1);
  localparam logic [JW-1:0] JAM_MAX  = JW'(JAM_CYCLES);
  localparam logic          SINGLE   = (DEBOUNCE_CYCLES == 1) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {IDLE = 2'd0, RISE_CHK = 2'd1, HIGH = 2'd2, FALL_CHK = 2'd3} state_t;

  logic [2:0] w_raw;
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [2:0] w_qual;
  logic [2:0] w_hit;
  logic [2:0] w_idle;
  logic       w_nickle_nx;
  logic       w_dime_nx;
  logic       w_quarter_nx;
  logic       w_reject_nx;
  logic       w_jam_nx;
  logic       r_nickle;
  logic       r_dime;
  logic       r_quarter;
  logic       r_reject;
  logic       r_jam;

  assign w_raw = {i_quarter_raw, i_dime_raw, i_nickle_raw};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_ch
    state_t          r_state;
    state_t          w_state_nx;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nx;
    logic [JW-1:0]   r_jcnt;
    logic [JW-1:0]   w_jcnt_nx;
    logic            w_qual_ch;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_jcnt  <= '0;
      end else begin
        r_state <= w_state_nx;
        r_cnt   <= w_cnt_nx;
        r_jcnt  <= w_jcnt_nx;
      end
    end

    always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_jcnt_nx  = r_jcnt;
      case (r_state)
        IDLE: begin
          w_jcnt_nx = '0;
          if (r_sync2[g]) begin
            if (SINGLE) begin
              w_state_nx = HIGH;
              w_cnt_nx   = '0;
            end else begin
              w_state_nx = RISE_CHK;
              w_cnt_nx   = CNT_ONE;
            end
          end else begin
            w_cnt_nx = '0;
          end
        end
        RISE_CHK: begin
          if (!r_sync2[g]) begin
            w_state_nx = IDLE;
            w_cnt_nx   = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nx = HIGH;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + CNT_ONE;
          end
        end
        HIGH: begin
          // Jam counter saturates; it is only cleared on return to IDLE.
          if (r_jcnt != JAM_MAX) begin
            w_jcnt_nx = r_jcnt + JAM_ONE;
          end else begin
            w_jcnt_nx = r_jcnt;
          end
          if (!r_sync2[g]) begin
            if (SINGLE) begin
              w_state_nx = IDLE;
              w_jcnt_nx  = '0;
            end else begin
              w_state_nx = FALL_CHK;
              w_cnt_nx   = CNT_ONE;
            end
          end else begin
            w_cnt_nx = '0;
          end
        end
        FALL_CHK: begin
          if (r_sync2[g]) begin
            w_state_nx = HIGH;
            w_cnt_nx   = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nx = IDLE;
            w_cnt_nx   = '0;
            w_jcnt_nx  = '0;
          end else begin
            w_cnt_nx = r_cnt + CNT_ONE;
          end
        end
        default: begin
          w_state_nx = IDLE;
          w_cnt_nx   = '0;
          w_jcnt_nx  = '0;
        end
      endcase
    end

    always_comb begin
      w_qual_ch = r_sync2[g] &&
                  (((r_state == RISE_CHK) && (r_cnt == CNT_LAST)) || ((r_state == IDLE) && SINGLE));
    end

    assign w_qual[g] = w_qual_ch;
    assign w_hit[g]  = (w_jcnt_nx == JAM_MAX);
    assign w_idle[g] = (r_state == IDLE);
  end

  // Arbitration over this cycle's qualifications plus jam flag update.
  always_comb begin
    w_nickle_nx  = 1'b0;
    w_dime_nx    = 1'b0;
    w_quarter_nx = 1'b0;
    w_reject_nx  = 1'b0;
    if (|w_hit) begin
      w_jam_nx = 1'b1;
    end else if (&w_idle) begin
      w_jam_nx = 1'b0;
    end else begin
      w_jam_nx = r_jam;
    end
    case (w_qual)
      3'b000: w_reject_nx = 1'b0;
      3'b001: if (i_enable && !r_jam) w_nickle_nx  = 1'b1; else w_reject_nx = 1'b1;
      3'b010: if (i_enable && !r_jam) w_dime_nx    = 1'b1; else w_reject_nx = 1'b1;
      3'b100: if (i_enable && !r_jam) w_quarter_nx = 1'b1; else w_reject_nx = 1'b1;
      default: w_reject_nx = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_nickle  <= 1'b0;
      r_dime    <= 1'b0;
      r_quarter <= 1'b0;
      r_reject  <= 1'b0;
      r_jam     <= 1'b0;
    end else begin
      r_nickle  <= w_nickle_nx;
      r_dime    <= w_dime_nx;
      r_quarter <= w_quarter_nx;
      r_reject  <= w_reject_nx;
      r_jam     <= w_jam_nx;
    end
  end

  assign o_nickle  = r_nickle;
  assign o_dime    = r_dime;
  assign o_quarter = r_quarter;
  assign o_reject  = r_reject;
  assign o_jam     = r_jam;

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Scoreboard bench for coin_input_conditioner: a cycle-level reference model built
// from debounce run-lengths and time-in-high pushes expected outputs; a monitor compares.
module tb_coin_input_conditioner;

  localparam int DEB = 4;
  localparam int JAM = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic n_raw = 1'b0;
  logic d_raw = 1'b0;
  logic q_raw = 1'b0;
  logic o_n, o_d, o_q, o_rej, o_jam;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  coin_input_conditioner #(.DEBOUNCE_CYCLES(DEB), .JAM_CYCLES(JAM)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(en),
    .i_nickle_raw(n_raw), .i_dime_raw(d_raw), .i_quarter_raw(q_raw),
    .o_nickle(o_n), .o_dime(o_d), .o_quarter(o_q), .o_reject(o_rej), .o_jam(o_jam)
  );

  // expected vector layout: {nickel, dime, quarter, reject, jam}
  logic [4:0] exp_q[$];

  bit m_s1[3];
  bit m_s2[3];
  bit m_lvl[3];
  bit m_last[3];
  int m_run[3];
  int m_high[3];
  bit m_jam;

  // Reference model: a level flips after DEB consecutive synced samples that disagree with it.
  always @(posedge clk) begin : model
    bit raw[3];
    bit s;
    bit qual[3];
    int nq;
    bit idle_all;
    bit hit;
    logic [4:0] v;
    cyc++;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_last[i] = 0; m_run[i] = 0; m_high[i] = 0;
      end
      m_jam = 0;
      exp_q.push_back(5'b00000);
    end else begin
      raw[0] = n_raw; raw[1] = d_raw; raw[2] = q_raw;
      idle_all = 1;
      for (int i = 0; i < 3; i++) if (m_lvl[i] || m_last[i]) idle_all = 0;
      hit = 0;
      nq = 0;
      for (int i = 0; i < 3; i++) begin
        s = m_s2[i];
        m_s2[i] = m_s1[i];
        m_s1[i] = raw[i];
        qual[i] = 0;
        if (m_lvl[i] && m_last[i] && m_high[i] < JAM) m_high[i]++;
        if (s != m_lvl[i]) m_run[i]++; else m_run[i] = 0;
        if (m_run[i] == DEB) begin
          m_lvl[i] = s;
          m_run[i] = 0;
          if (s) qual[i] = 1; else m_high[i] = 0;
        end
        m_last[i] = s;
        if (m_high[i] == JAM) hit = 1;
        if (qual[i]) nq++;
      end
      v = 5'b00000;
      if (nq > 1 || (nq == 1 && (!en || m_jam))) v[1] = 1'b1;
      else if (nq == 1) begin
        if (qual[0]) v[4] = 1'b1;
        else if (qual[1]) v[3] = 1'b1;
        else v[2] = 1'b1;
      end
      if (hit) m_jam = 1;
      else if (idle_all) m_jam = 0;
      v[0] = m_jam;
      exp_q.push_back(v);
    end
  end

  int cnt_n, cnt_d, cnt_q, cnt_rej, cnt_jr;
  int t_dpulse, t_jfall;
  bit prev_jam = 0;

  always @(negedge clk) begin : monitor
    logic [4:0] act;
    logic [4:0] e;
    act = {o_n, o_d, o_q, o_rej, o_jam};
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_underflow cyc=%0d actual=%b", cyc, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        fails++;
        $display("FAIL scoreboard cyc=%0d actual=%b expected=%b", cyc, act, e);
      end
    end
    cnt_n += int'(o_n);
    cnt_d += int'(o_d);
    cnt_q += int'(o_q);
    cnt_rej += int'(o_rej);
    if (o_jam && !prev_jam) cnt_jr++;
    if (!o_jam && prev_jam) t_jfall = cyc;
    if (o_d && t_dpulse < 0) t_dpulse = cyc;
    prev_jam = o_jam;
  end

  task automatic step(input bit n, input bit d, input bit q, input bit e, input int k);
    repeat (k) begin
      @(negedge clk);
      #1;
      n_raw = n; d_raw = d; q_raw = q; en = e;
    end
  endtask

  task automatic clr();
    cnt_n = 0; cnt_d = 0; cnt_q = 0; cnt_rej = 0; cnt_jr = 0;
    t_dpulse = -1; t_jfall = -1;
  endtask

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  task automatic pulse_rst();
    @(negedge clk); #1; rst = 1'b1;
    @(negedge clk); #1; rst = 1'b0;
  endtask

  int t_on, t_off;

  initial begin
    clr();
    step(0, 0, 0, 1, 3);
    chk("reset_outputs", int'({o_n, o_d, o_q, o_rej, o_jam}), 0);
    @(negedge clk); #1; rst = 1'b0;

    // 1: clean dime, latency = 2 sync + DEB - 1 edges after first high sample
    clr();
    step(0, 1, 0, 1, 1);
    t_on = cyc + 1;
    step(0, 1, 0, 1, 19);
    step(0, 0, 0, 1, 12);
    chk("t1_dime_count", cnt_d, 1);
    chk("t1_reject", cnt_rej, 0);
    chk("t1_latency", t_dpulse - t_on, 2 + DEB - 1);

    // 2: bounce then stable nickel
    clr();
    step(1, 0, 0, 1, 1); step(0, 0, 0, 1, 1); step(1, 0, 0, 1, 2); step(0, 0, 0, 1, 1);
    step(1, 0, 0, 1, 10);
    step(0, 0, 0, 1, 12);
    chk("t2_nickel_count", cnt_n, 1);
    chk("t2_reject", cnt_rej, 0);

    // 3: simultaneous nickel and quarter
    clr();
    step(1, 0, 1, 1, 10);
    step(0, 0, 0, 1, 12);
    chk("t3_reject", cnt_rej, 1);
    chk("t3_nickel", cnt_n, 0);
    chk("t3_quarter", cnt_q, 0);

    // 4: disabled quarter, then enabled quarter
    clr();
    step(0, 0, 1, 0, 10);
    step(0, 0, 0, 0, 12);
    chk("t4_dis_reject", cnt_rej, 1);
    chk("t4_dis_quarter", cnt_q, 0);
    clr();
    step(0, 0, 1, 1, 10);
    step(0, 0, 0, 1, 12);
    chk("t4_en_quarter", cnt_q, 1);
    chk("t4_en_reject", cnt_rej, 0);

    // 5: jammed dime with a nickel inserted during the jam
    clr();
    step(0, 1, 0, 1, 25);
    step(1, 1, 0, 1, 10);
    step(0, 1, 0, 1, 5);
    step(0, 0, 0, 1, 1);
    t_off = cyc + 1;
    step(0, 0, 0, 1, 15);
    chk("t5_jam_rises", cnt_jr, 1);
    chk("t5_dime", cnt_d, 1);
    chk("t5_nickel", cnt_n, 0);
    chk("t5_reject", cnt_rej, 1);
    chk("t5_jam_fall", t_jfall - t_off, DEB + 2);
    chk("t5_jam_low", int'(o_jam), 0);

    // 6: reset mid rising check with quarter held high
    clr();
    step(0, 0, 1, 1, 4);
    pulse_rst();
    step(0, 0, 1, 1, 15);
    step(0, 0, 0, 1, 12);
    chk("t6_quarter", cnt_q, 1);
    chk("t6_reject", cnt_rej, 0);

    // randomized traffic, occasional resets and enable drops
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 39) == 0) pulse_rst();
      step(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 4) != 0), $urandom_range(1, 24));
    end
    step(0, 0, 0, 1, 30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
